// File: rtl/fifo_byte_drain_if.sv
// fifo_byte_drain_if
//   Groups the FIFO read port and the byte stream of fifo_byte_drain.
//   master : the drain side (pops the FIFO, drives the byte stream)
//   slave  : the environment side (FIFO + byte sink)
//   Signals:
//     fifo_empty  FIFO empty flag                      (to drain)
//     fifo_data   FIFO data_out, valid cycle after rd  (to drain)
//     fifo_rd     single-cycle FIFO read strobe        (from drain)
//     byte_out    current output byte                  (from drain)
//     byte_valid  byte_out holds a valid byte          (from drain)
//     byte_ready  sink accepts on valid && ready       (to drain)
interface fifo_byte_drain_if #(
    parameter int WORD_W = 32,
    parameter int BYTE_W = 8
);
    logic              fifo_empty;
    logic [WORD_W-1:0] fifo_data;
    logic              fifo_rd;
    logic [BYTE_W-1:0] byte_out;
    logic              byte_valid;
    logic              byte_ready;

    modport master (
        input  fifo_empty, fifo_data, byte_ready,
        output fifo_rd, byte_out, byte_valid
    );

    modport slave (
        output fifo_empty, fifo_data, byte_ready,
        input  fifo_rd, byte_out, byte_valid
    );
endinterface

// File: rtl/fifo_byte_drain.sv
// fifo_byte_drain
//   Pops words from a word FIFO one at a time and emits each as
//   WORD_W/BYTE_W bytes, LSB first, on a valid/ready byte stream.
//   Ports:
//     clk         clock, all logic on posedge
//     reset       synchronous active-high reset
//     enable      1 = allowed to pop new words
//     bus         fifo_byte_drain_if.master (FIFO rd port + byte stream);
//                 its WORD_W/BYTE_W must match this module's parameters
//     busy        1 whenever the FSM is not IDLE
//     word_count  fully transmitted words, wraps modulo 2^CNT_W
module fifo_byte_drain #(
    parameter int WORD_W = 32,
    parameter int BYTE_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    fifo_byte_drain_if.master      bus,
    output logic                   busy,
    output logic [CNT_W-1:0]       word_count
);
    localparam int NB    = WORD_W / BYTE_W;
    localparam int IDX_W = (NB > 1) ? $clog2(NB) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NB - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        POP     = 2'd1,
        CAPTURE = 2'd2,
        SEND    = 2'd3
    } state_t;

    state_t            state, state_next;
    logic [WORD_W-1:0] shift_reg;
    logic [IDX_W-1:0]  byte_idx;

    logic accept;
    logic last_accept;
    logic can_pop;

    assign accept      = (state == SEND) && bus.byte_ready;
    assign last_accept = accept && (byte_idx == LAST_IDX);
    // Empty is only consulted in the cycle that decides to enter POP, so
    // the read strobe can never be issued against an empty FIFO.
    assign can_pop     = enable && !bus.fifo_empty;

    // Moore outputs: the strobe and valid depend on state only.
    assign bus.fifo_rd    = (state == POP);
    assign bus.byte_valid = (state == SEND);
    assign bus.byte_out   = shift_reg[BYTE_W-1:0];
    assign busy           = (state != IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (can_pop) state_next = POP;
            POP:     state_next = CAPTURE;
            CAPTURE: state_next = SEND;
            SEND: begin
                if (last_accept) begin
                    state_next = can_pop ? POP : IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Datapath: load in CAPTURE, shift one byte down per accepted byte.
    always_ff @(posedge clk) begin
        if (reset) begin
            shift_reg  <= '0;
            byte_idx   <= '0;
            word_count <= '0;
        end else begin
            if (state == CAPTURE) begin
                shift_reg <= bus.fifo_data;
                byte_idx  <= '0;
            end else if (accept) begin
                shift_reg <= shift_reg >> BYTE_W;
                byte_idx  <= byte_idx + 1'b1;
                if (last_accept) begin
                    word_count <= word_count + 1'b1;
                end
            end
        end
    end
endmodule
